cam_array_seq: RTL and testbench
================================

# cam_array_seq

Sequencer that sits directly upstream of the 9T CAM cell array and drives its write wordlines, data lines, search lines and matchline precharge. It turns single-cycle write, search and invalidate requests into properly phased array pulses: data setup, then wordline pulse, then hold for writes, and precharge, then evaluate, then capture for searches. It also keeps a per-row valid mask and priority-encodes the sampled matchlines into a one-cycle search response.

## Interface
- ROWS, 8, number of CAM words (rows); one WLWR line per row
- WIDTH, 4, bits per word; one DL/DLB and SL/SLB pair per column
- AW, 3, address width, must satisfy 2^AW >= ROWS
- WPULSE_CYC, 2, wordline high time in cycles (>=1)
- EVAL_CYC, 2, matchline evaluate time in cycles (>=1)

Ports:
- CLK  in  1  single clock, rising edge
- RSTB  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  high only in IDLE; a request is accepted on an edge where REQ_VALID && REQ_READY
- REQ_OP  in  2  00 write, 01 search, 10 invalidate, 11 reserved (treated as invalidate with no effect)
- REQ_ADDR  in  AW  target row for write or invalidate
- REQ_DATA  in  WIDTH  write data or search key
- WLWR  out  ROWS  one-hot write wordlines, active high
- DL, DLB  out  WIDTH each  write data lines, true and complement
- SL, SLB  out  WIDTH each  search lines, true and complement
- MLPRE_B  out  1  matchline precharge, active low
- ML  in  ROWS  matchlines from the array, high means match
- WDONE  out  1  one-cycle pulse when a write or invalidate completes
- RSP_VALID  out  1  one-cycle pulse carrying the search result
- RSP_HIT, RSP_MULTI  out  1 each  at least one valid match; more than one valid match
- RSP_ADDR  out  AW  lowest-index matching valid row; 0 when there is no hit
- VALID  out  ROWS  per-row valid mask (registered)

## Operation
- All outputs except REQ_READY are flops. REQ_READY = (state == IDLE).
- Reset (RSTB low, async): state IDLE; WLWR=0, DL=DLB=0, SL=SLB=0, MLPRE_B=1, WDONE=0, RSP_*=0, VALID=0. Reset mid-operation aborts immediately and WLWR drops without waiting for CLK.
- At accept, REQ_OP, REQ_ADDR and REQ_DATA are latched. Later input changes are ignored until REQ_READY returns high.
- Idle line levels: DL=DLB=0 and SL=SLB=0, so columns are not driven. MLPRE_B=1.
- States: IDLE, WSETUP, WPULSE, WHOLD, INV, SPRE, SEVAL, RESP.
- Write (op 00): IDLE→WSETUP→WPULSE (WPULSE_CYC cycles)→WHOLD→IDLE.
  - WSETUP: DL=data, DLB=~data, WLWR=0.
  - WPULSE: WLWR[addr]=1, with DL/DLB held.
  - WHOLD: WLWR=0, DL/DLB held, WDONE=1, and VALID[addr] is set at the end of WHOLD.
  - On return to IDLE, DL and DLB go to 0.
- Invalidate (op 10): IDLE→INV→IDLE. In INV, WDONE=1 and VALID[addr] is cleared. The array is not touched.
- Search (op 01): IDLE→SPRE→SEVAL (EVAL_CYC cycles)→RESP→IDLE.
  - SPRE: MLPRE_B=0, SL=SLB=0.
  - SEVAL: MLPRE_B=1, SL=key, SLB=~key.
  - On the final SEVAL edge, hitvec = ML & VALID is captured.
  - RESP: SL=SLB=0, RSP_VALID=1, RSP_HIT=|hitvec, RSP_MULTI=(popcount(hitvec)>1), RSP_ADDR=lowest set index.
- Out-of-range address (REQ_ADDR >= ROWS) on write: the full sequence still runs, no WLWR bit rises, WDONE still pulses, VALID is unchanged. On invalidate, no effect besides WDONE.
- Writing to an already-valid row overwrites it; VALID stays 1.
- Rows with VALID=0 never report a hit, even if ML is high.

## Timing
- Accept edge E0. Write: WSETUP after E0, WLWR high after E1 through E(WPULSE_CYC), WDONE high after E(1+WPULSE_CYC), REQ_READY high again after E(2+WPULSE_CYC). Defaults give a 4-cycle occupancy.
- Invalidate: WDONE high after E0, REQ_READY high after E1.
- Search: MLPRE_B low after E0, SL valid after E1, ML sampled at E(1+EVAL_CYC), RSP_VALID high after that edge for exactly one cycle, REQ_READY high one cycle later. Defaults give a 4-cycle occupancy.
- WLWR and MLPRE_B are never active in the same cycle. DL/DLB are stable for ≥1 cycle on each side of the WLWR pulse.
- Back-to-back requests: the next accept happens on the first edge with REQ_READY=1, with no bubble beyond the occupancy above.

## Test plan
- Reset with RSTB low mid-WPULSE: WLWR goes to 0 asynchronously, VALID=0, and REQ_READY=1 after release.
- Write addr 3, data 4'b1010: DL=1010 and DLB=0101 for 4 cycles, WLWR=8'h08 for exactly 2 cycles, WDONE a single pulse, VALID=8'h08.
- Write rows 2 and 5, search with ML forced to 8'h24: RSP_HIT=1, RSP_MULTI=1, RSP_ADDR=2. MLPRE_B is low exactly one cycle before SL is driven.
- Search with ML=8'hFF and VALID=0: RSP_HIT=0, RSP_ADDR=0, RSP_MULTI=0.
- Invalidate row 2 after the above, then search with ML=8'h24: RSP_HIT=1, RSP_ADDR=5, RSP_MULTI=0.
- Write to addr 7 with ROWS=6, and REQ_VALID held high with changing data while busy: no WLWR bit rises, WDONE pulses, VALID is unchanged, and only one request is accepted per REQ_READY window.

Source files
------------

// File: rtl/cam_array_seq.sv
// cam_array_seq: phases single-cycle write / search / invalidate requests
// into the wordline, data line, search line and matchline precharge pulses
// of a 9T CAM array. It also keeps the per-row valid mask and turns the
// sampled matchlines into a one-cycle priority-encoded search response.
module cam_array_seq #(
    parameter int ROWS       = 8,
    parameter int WIDTH      = 4,
    parameter int AW         = 3,
    parameter int WPULSE_CYC = 2,
    parameter int EVAL_CYC   = 2
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [AW-1:0]    REQ_ADDR,
    input  logic [WIDTH-1:0] REQ_DATA,
    output logic [ROWS-1:0]  WLWR,
    output logic [WIDTH-1:0] DL,
    output logic [WIDTH-1:0] DLB,
    output logic [WIDTH-1:0] SL,
    output logic [WIDTH-1:0] SLB,
    output logic             MLPRE_B,
    input  logic [ROWS-1:0]  ML,
    output logic             WDONE,
    output logic             RSP_VALID,
    output logic             RSP_HIT,
    output logic             RSP_MULTI,
    output logic [AW-1:0]    RSP_ADDR,
    output logic [ROWS-1:0]  VALID
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WSETUP = 3'd1,
        ST_WPULSE = 3'd2,
        ST_WHOLD  = 3'd3,
        ST_INV    = 3'd4,
        ST_SPRE   = 3'd5,
        ST_SEVAL  = 3'd6,
        ST_RESP   = 3'd7
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SEARCH = 2'b01;
    localparam logic [1:0] OP_INV    = 2'b10;

    // Phase counter; wide enough for any practical pulse/evaluate length.
    localparam int CW = 8;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [1:0]        op_r;
    logic [AW-1:0]     addr_r;
    logic [WIDTH-1:0]  data_r;

    logic [ROWS-1:0]   wlwr_r;
    logic [WIDTH-1:0]  dl_r;
    logic [WIDTH-1:0]  dlb_r;
    logic [WIDTH-1:0]  sl_r;
    logic [WIDTH-1:0]  slb_r;
    logic              mlpre_b_r;
    logic              wdone_r;
    logic              rsp_valid_r;
    logic              rsp_hit_r;
    logic              rsp_multi_r;
    logic [AW-1:0]     rsp_addr_r;
    logic [ROWS-1:0]   valid_r;

    logic [ROWS-1:0]   hit_s;

    // One-hot row decode; an address beyond the last row selects nothing,
    // which is what makes out-of-range writes and invalidates harmless.
    function automatic logic [ROWS-1:0] row_sel(input logic [AW-1:0] a);
        logic [ROWS-1:0] v;
        v = {ROWS{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            if (a == AW'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Lowest-index set bit; zero when the vector is empty.
    function automatic logic [AW-1:0] lowest_idx(input logic [ROWS-1:0] v);
        logic [AW-1:0] idx;
        idx = {AW{1'b0}};
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = AW'(i);
            end
        end
        return idx;
    endfunction

    // True when two or more bits are set.
    function automatic logic multi_set(input logic [ROWS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return (n > 1);
    endfunction

    // Invalid rows are masked so a stale matchline can never report a hit.
    assign hit_s     = ML & valid_r;
    assign REQ_READY = (state_r == ST_IDLE);

    assign WLWR      = wlwr_r;
    assign DL        = dl_r;
    assign DLB       = dlb_r;
    assign SL        = sl_r;
    assign SLB       = slb_r;
    assign MLPRE_B   = mlpre_b_r;
    assign WDONE     = wdone_r;
    assign RSP_VALID = rsp_valid_r;
    assign RSP_HIT   = rsp_hit_r;
    assign RSP_MULTI = rsp_multi_r;
    assign RSP_ADDR  = rsp_addr_r;
    assign VALID     = valid_r;

    // Sequencer: walks each request through its phases and drives every array-facing flop.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            op_r        <= 2'b00;
            addr_r      <= {AW{1'b0}};
            data_r      <= {WIDTH{1'b0}};
            wlwr_r      <= {ROWS{1'b0}};
            dl_r        <= {WIDTH{1'b0}};
            dlb_r       <= {WIDTH{1'b0}};
            sl_r        <= {WIDTH{1'b0}};
            slb_r       <= {WIDTH{1'b0}};
            mlpre_b_r   <= 1'b1;
            wdone_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_multi_r <= 1'b0;
            rsp_addr_r  <= {AW{1'b0}};
            valid_r     <= {ROWS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        op_r   <= REQ_OP;
                        addr_r <= REQ_ADDR;
                        data_r <= REQ_DATA;
                        case (REQ_OP)
                            OP_WRITE: begin
                                // Data lines set up a full cycle ahead of the wordline.
                                state_r <= ST_WSETUP;
                                dl_r    <= REQ_DATA;
                                dlb_r   <= ~REQ_DATA;
                            end
                            OP_SEARCH: begin
                                state_r   <= ST_SPRE;
                                mlpre_b_r <= 1'b0;
                            end
                            default: begin
                                // Invalidate, and the reserved op as a no-op invalidate.
                                state_r <= ST_INV;
                                wdone_r <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WSETUP: begin
                    wlwr_r  <= row_sel(addr_r);
                    cnt_r   <= CW'(WPULSE_CYC - 1);
                    state_r <= ST_WPULSE;
                end
                ST_WPULSE: begin
                    if (cnt_r == 8'd0) begin
                        wlwr_r  <= {ROWS{1'b0}};
                        wdone_r <= 1'b1;
                        state_r <= ST_WHOLD;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_WHOLD: begin
                    // Data lines released only after a full hold cycle.
                    wdone_r <= 1'b0;
                    dl_r    <= {WIDTH{1'b0}};
                    dlb_r   <= {WIDTH{1'b0}};
                    valid_r <= valid_r | row_sel(addr_r);
                    state_r <= ST_IDLE;
                end
                ST_INV: begin
                    wdone_r <= 1'b0;
                    if (op_r == OP_INV) begin
                        valid_r <= valid_r & ~row_sel(addr_r);
                    end else begin
                        valid_r <= valid_r;
                    end
                    state_r <= ST_IDLE;
                end
                ST_SPRE: begin
                    // Precharge ends before the search lines are driven.
                    mlpre_b_r <= 1'b1;
                    sl_r      <= data_r;
                    slb_r     <= ~data_r;
                    cnt_r     <= CW'(EVAL_CYC - 1);
                    state_r   <= ST_SEVAL;
                end
                ST_SEVAL: begin
                    if (cnt_r == 8'd0) begin
                        sl_r        <= {WIDTH{1'b0}};
                        slb_r       <= {WIDTH{1'b0}};
                        rsp_valid_r <= 1'b1;
                        rsp_hit_r   <= |hit_s;
                        rsp_multi_r <= multi_set(hit_s);
                        rsp_addr_r  <= lowest_idx(hit_s);
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= 1'b0;
                    rsp_hit_r   <= 1'b0;
                    rsp_multi_r <= 1'b0;
                    rsp_addr_r  <= {AW{1'b0}};
                    state_r     <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: park every line in its idle level.
                    wlwr_r      <= {ROWS{1'b0}};
                    dl_r        <= {WIDTH{1'b0}};
                    dlb_r       <= {WIDTH{1'b0}};
                    sl_r        <= {WIDTH{1'b0}};
                    slb_r       <= {WIDTH{1'b0}};
                    mlpre_b_r   <= 1'b1;
                    wdone_r     <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_array_seq.sv
// Testbench for cam_array_seq: a vector table of requests with hand-derived
// responses, a scoreboard of expected WDONE / RSP pulses, and hand-written
// phase sequences for write, invalidate, search, busy and mid-pulse reset.
module tb_cam_array_seq;

    logic       CLK = 1'b0;
    logic       RSTB = 1'b0;

    // Main instance, default geometry.
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [1:0] REQ_OP = 2'b00;
    logic [2:0] REQ_ADDR = 3'd0;
    logic [3:0] REQ_DATA = 4'h0;
    logic [7:0] WLWR;
    logic [3:0] DL, DLB, SL, SLB;
    logic       MLPRE_B;
    logic [7:0] ML = 8'h00;
    logic       WDONE, RSP_VALID, RSP_HIT, RSP_MULTI;
    logic [2:0] RSP_ADDR;
    logic [7:0] VALID;

    // Second instance with 6 rows for out-of-range addressing.
    logic       r1_valid = 1'b0;
    logic       r1_ready;
    logic [1:0] r1_op = 2'b00;
    logic [2:0] r1_addr = 3'd0;
    logic [3:0] r1_data = 4'h0;
    logic [5:0] r1_wlwr;
    logic [3:0] r1_dl, r1_dlb, r1_sl, r1_slb;
    logic       r1_mlpre;
    logic [5:0] r1_ml = 6'h00;
    logic       r1_wdone, r1_rspv, r1_hit, r1_multi;
    logic [2:0] r1_raddr;
    logic [5:0] r1_vmask;

    cam_array_seq dut (
        .CLK(CLK), .RSTB(RSTB), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .WLWR(WLWR), .DL(DL), .DLB(DLB), .SL(SL), .SLB(SLB),
        .MLPRE_B(MLPRE_B), .ML(ML), .WDONE(WDONE), .RSP_VALID(RSP_VALID),
        .RSP_HIT(RSP_HIT), .RSP_MULTI(RSP_MULTI), .RSP_ADDR(RSP_ADDR),
        .VALID(VALID)
    );

    cam_array_seq #(.ROWS(6)) dut6 (
        .CLK(CLK), .RSTB(RSTB), .REQ_VALID(r1_valid), .REQ_READY(r1_ready),
        .REQ_OP(r1_op), .REQ_ADDR(r1_addr), .REQ_DATA(r1_data),
        .WLWR(r1_wlwr), .DL(r1_dl), .DLB(r1_dlb), .SL(r1_sl), .SLB(r1_slb),
        .MLPRE_B(r1_mlpre), .ML(r1_ml), .WDONE(r1_wdone), .RSP_VALID(r1_rspv),
        .RSP_HIT(r1_hit), .RSP_MULTI(r1_multi), .RSP_ADDR(r1_raddr),
        .VALID(r1_vmask)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard of expected completion pulses.
    typedef struct packed {
        logic       srch;
        logic       hit;
        logic       multi;
        logic [2:0] addr;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Vector table: request plus hand-derived response and resulting mask.
    typedef struct {
        logic [1:0] op;
        logic [2:0] addr;
        logic [3:0] data;
        logic [7:0] ml;
        logic       hit;
        logic       multi;
        logic [2:0] raddr;
        logic [7:0] valid;
    } vec_t;
    vec_t vecs[18];

    // Accept counter for the 6-row instance.
    int acc1 = 0;
    always @(posedge CLK) if (r1_valid && r1_ready) acc1++;

    // Monitor: interlock check each cycle and scoreboard pop on every pulse.
    always @(negedge CLK) begin
        if (RSTB) begin
            check("wl_pre_overlap", 32'(|WLWR & ~MLPRE_B), 32'd0);
            if (WDONE || RSP_VALID) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pulse: got WDONE=%0b RSP_VALID=%0b expected none at %0t",
                             WDONE, RSP_VALID, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_kind", 32'({WDONE, RSP_VALID}), mon_e.srch ? 32'd1 : 32'd2);
                    if (mon_e.srch) begin
                        check("rsp_hit",   32'(RSP_HIT),   32'(mon_e.hit));
                        check("rsp_multi", 32'(RSP_MULTI), 32'(mon_e.multi));
                        check("rsp_addr",  32'(RSP_ADDR),  32'(mon_e.addr));
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] addr, input logic [3:0] data,
                         input logic [7:0] ml, input logic hit, input logic multi,
                         input logic [2:0] raddr);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge CLK);
        while (!REQ_READY && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (!REQ_READY) begin
            n_checks++;
            $display("FAIL ready_timeout: got REQ_READY=0 expected 1 within 20 cycles");
        end
        REQ_OP = op; REQ_ADDR = addr; REQ_DATA = data; ML = ml; REQ_VALID = 1'b1;
        e.srch = (op == 2'b01); e.hit = hit; e.multi = multi; e.addr = raddr;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge CLK);
        while (!REQ_READY && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (!REQ_READY) begin
            n_checks++;
            $display("FAIL idle_timeout: got REQ_READY=0 expected 1 within 20 cycles");
        end
    endtask

    initial begin
        logic [7:0] ew_wl[5]  = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h00};
        logic [3:0] ew_dl[5]  = '{4'hA, 4'hA, 4'hA, 4'hA, 4'h0};
        logic [3:0] ew_dlb[5] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h0};
        logic       ew_dn[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       e_rdy[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       es_pre[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] es_sl[5]  = '{4'h0, 4'hC, 4'hC, 4'h0, 4'h0};
        logic [3:0] es_slb[5] = '{4'h0, 4'h3, 4'h3, 4'h0, 4'h0};
        logic       es_rv[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [5:0] wl_or;
        int         wd_cnt;
        int         acc_start;

        vecs[0]  = '{2'b01, 3'd0, 4'h0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[1]  = '{2'b00, 3'd3, 4'hA, 8'h00, 1'b0, 1'b0, 3'd0, 8'h08};
        vecs[2]  = '{2'b00, 3'd2, 4'h6, 8'h00, 1'b0, 1'b0, 3'd0, 8'h0C};
        vecs[3]  = '{2'b00, 3'd5, 4'h3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h2C};
        vecs[4]  = '{2'b01, 3'd0, 4'h9, 8'h24, 1'b1, 1'b1, 3'd2, 8'h2C};
        vecs[5]  = '{2'b10, 3'd2, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h28};
        vecs[6]  = '{2'b01, 3'd0, 4'h9, 8'h24, 1'b1, 1'b0, 3'd5, 8'h28};
        vecs[7]  = '{2'b11, 3'd5, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h28};
        vecs[8]  = '{2'b01, 3'd0, 4'hF, 8'hFF, 1'b1, 1'b1, 3'd3, 8'h28};
        vecs[9]  = '{2'b00, 3'd3, 4'hF, 8'h00, 1'b0, 1'b0, 3'd0, 8'h28};
        vecs[10] = '{2'b01, 3'd0, 4'hF, 8'h08, 1'b1, 1'b0, 3'd3, 8'h28};
        vecs[11] = '{2'b10, 3'd3, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h20};
        vecs[12] = '{2'b10, 3'd5, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[13] = '{2'b01, 3'd0, 4'h0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[14] = '{2'b00, 3'd0, 4'h1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01};
        vecs[15] = '{2'b00, 3'd7, 4'h8, 8'h00, 1'b0, 1'b0, 3'd0, 8'h81};
        vecs[16] = '{2'b01, 3'd0, 4'h2, 8'h80, 1'b1, 1'b0, 3'd7, 8'h81};
        vecs[17] = '{2'b01, 3'd0, 4'h2, 8'h01, 1'b1, 1'b0, 3'd0, 8'h81};

        // Reset values.
        #12;
        check("rst_wlwr",  32'(WLWR), 32'h00);
        check("rst_dl",    32'({DL, DLB, SL, SLB}), 32'h0000);
        check("rst_mlpre", 32'(MLPRE_B), 32'd1);
        check("rst_pulses", 32'({WDONE, RSP_VALID, RSP_HIT, RSP_MULTI, RSP_ADDR}), 32'd0);
        check("rst_valid", 32'(VALID), 32'h00);
        check("rst_ready", 32'(REQ_READY), 32'd1);
        @(negedge CLK);
        RSTB = 1'b1;

        // Write row 3 with 1010: phase-by-phase line levels.
        issue(2'b00, 3'd3, 4'hA, 8'h00, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check($sformatf("w_wlwr_%0d", k), 32'(WLWR), 32'(ew_wl[k]));
            check($sformatf("w_dl_%0d", k),   32'(DL),   32'(ew_dl[k]));
            check($sformatf("w_dlb_%0d", k),  32'(DLB),  32'(ew_dlb[k]));
            check($sformatf("w_done_%0d", k), 32'(WDONE), 32'(ew_dn[k]));
            check($sformatf("w_rdy_%0d", k),  32'(REQ_READY), 32'(e_rdy[k]));
        end
        check("w_valid", 32'(VALID), 32'h08);

        // Invalidate row 3: WDONE after accept, ready one cycle later.
        issue(2'b10, 3'd3, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);
        @(negedge CLK);
        check("inv_done0", 32'({WDONE, REQ_READY}), 32'd2);
        @(negedge CLK);
        check("inv_done1", 32'({WDONE, REQ_READY}), 32'd1);
        check("inv_valid", 32'(VALID), 32'h00);

        // Table-driven requests.
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].ml,
                  vecs[i].hit, vecs[i].multi, vecs[i].raddr);
            wait_idle();
            check($sformatf("vec%0d_valid", i), 32'(VALID), 32'(vecs[i].valid));
        end

        // Search phasing with rows 0 and 7 valid, both matching.
        issue(2'b01, 3'd0, 4'hC, 8'h81, 1'b1, 1'b1, 3'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check($sformatf("s_pre_%0d", k), 32'(MLPRE_B), 32'(es_pre[k]));
            check($sformatf("s_sl_%0d", k),  32'(SL),  32'(es_sl[k]));
            check($sformatf("s_slb_%0d", k), 32'(SLB), 32'(es_slb[k]));
            check($sformatf("s_rv_%0d", k),  32'(RSP_VALID), 32'(es_rv[k]));
            check($sformatf("s_rdy_%0d", k), 32'(REQ_READY), 32'(e_rdy[k]));
        end

        // 6-row instance: write to row 7 with REQ_VALID held and inputs churning.
        acc_start = acc1;
        wl_or = 6'h00;
        wd_cnt = 0;
        @(negedge CLK);
        r1_op = 2'b00; r1_addr = 3'd7; r1_data = 4'h5; r1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            wl_or = wl_or | r1_wlwr;
            if (r1_wdone) wd_cnt++;
            if (r1_ready) r1_valid = 1'b0;
            else begin
                r1_addr = 3'd1;
                r1_data = 4'($urandom_range(0, 15));
            end
        end
        check("oor_accepts", 32'(acc1 - acc_start), 32'd1);
        check("oor_wlwr",    32'(wl_or), 32'h00);
        check("oor_wdone",   32'(wd_cnt), 32'd1);
        check("oor_valid",   32'(r1_vmask), 32'h00);

        // Reset in the middle of the wordline pulse.
        issue(2'b00, 3'd6, 4'h1, 8'h00, 1'b0, 1'b0, 3'd0);
        @(negedge CLK);
        @(negedge CLK);
        check("mid_wlwr_pre", 32'(WLWR), 32'h40);
        #2;
        RSTB = 1'b0;
        sb.delete();
        #1;
        check("mid_wlwr_async", 32'(WLWR), 32'h00);
        check("mid_valid", 32'(VALID), 32'h00);
        check("mid_dl", 32'({DL, DLB}), 32'h00);
        @(negedge CLK);
        RSTB = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("post_rst_ready", 32'(REQ_READY), 32'd1);
        check("post_rst_wlwr",  32'(WLWR), 32'h00);
        check("post_rst_valid", 32'(VALID), 32'h00);

        @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
